// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with count, threshold flags and error pulses
//
// Purpose: buffer between producer/consumer stages. Occupancy count and
// almost-full/almost-empty flags are registered from the same next-count
// value, so they always agree in any given cycle. DEPTH may be any integer
// >= 2; pointers wrap by explicit compare rather than by power-of-two overflow.
//
// Parameters:
//   WIDTH   data word width
//   DEPTH   number of entries
//   AF_LVL  o_almost_full when count >= AF_LVL
//   AE_LVL  o_almost_empty when count <= AE_LVL
//   FWFT    1 = head word shown combinationally, 0 = registered read
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_wdata, i_push      write data and write request
//   i_pop                read request
//   i_flush              synchronous clear (same effect as reset)
//   o_rdata              read data
//   o_full, o_empty      count == DEPTH / count == 0
//   o_almost_full/empty  threshold flags
//   o_count              current occupancy 0..DEPTH
//   o_overflow           one-cycle pulse: push requested while full
//   o_underflow          one-cycle pulse: pop requested while empty

module sync_fifo_flags #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1,
  parameter int FWFT   = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_almost_full,
  output logic             o_almost_empty,
  output logic [AW:0]      o_count,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int CW = AW + 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LVL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic push_acc;
  logic pop_acc;
  logic mem_we;

  always_comb begin
    push_acc = i_push & ~full_q;
    pop_acc  = i_pop & ~empty_q;
    mem_we   = push_acc & ~i_flush & ~i_rst;

    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_acc) begin
      wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
    end
    if (pop_acc) begin
      rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
    end

    // Flags come from the next count so they land on the same edge as o_count.
    count_d  = count_q + CW'(push_acc) - CW'(pop_acc);
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);

    // Error pulses look at the current flags, so a request that is
    // rejected in a given cycle pulses exactly once on the following cycle.
    ovf_d = i_push & full_q;
    udf_d = i_pop & empty_q;

    if (i_flush) begin
      wptr_d   = '0;
      rptr_d   = '0;
      count_d  = '0;
      full_d   = 1'b0;
      empty_d  = 1'b1;
      afull_d  = 1'b0;
      aempty_d = 1'b1;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is never cleared; reset only rewinds the pointers.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[wptr_q] <= i_wdata;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is visible whenever the FIFO is non-empty.
      assign o_rdata = mem[rptr_q];
    end else begin : g_reg
      logic [WIDTH-1:0] rdata_q, rdata_d;

      always_comb begin
        rdata_d = rdata_q;
        if (i_flush) begin
          rdata_d = '0;
        end else if (pop_acc) begin
          rdata_d = mem[rptr_q];
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          rdata_q <= '0;
        end else begin
          rdata_q <= rdata_d;
        end
      end

      assign o_rdata = rdata_q;
    end
  endgenerate

  assign o_full         = full_q;
  assign o_empty        = empty_q;
  assign o_almost_full  = afull_q;
  assign o_almost_empty = aempty_q;
  assign o_count        = count_q;
  assign o_overflow     = ovf_q;
  assign o_underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - scoreboard bench for sync_fifo_flags (DEPTH=5, both read modes)

module tb_sync_fifo_flags;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_flush = 1'b0;
  logic        i_push = 1'b0;
  logic        i_pop = 1'b0;
  logic [15:0] i_wdata = '0;

  logic [15:0] f_rdata, r_rdata;
  logic        f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic        r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
  logic [3:0]  f_count, r_count;

  int compared = 0;
  int mismatched = 0;
  int m_cnt = 0;
  logic reg_pend = 1'b0;

  logic [15:0] q_fwft[$];
  logic [15:0] q_reg[$];

  always #5 clk = ~clk;

  sync_fifo_flags #(.WIDTH(16), .DEPTH(5), .AF_LVL(4), .AE_LVL(1), .FWFT(1)) u_fwft (
    .i_clk(clk), .i_rst(i_rst), .i_wdata(i_wdata), .i_push(i_push), .i_pop(i_pop),
    .i_flush(i_flush), .o_rdata(f_rdata), .o_full(f_full), .o_empty(f_empty),
    .o_almost_full(f_af), .o_almost_empty(f_ae), .o_count(f_count),
    .o_overflow(f_ovf), .o_underflow(f_udf)
  );

  sync_fifo_flags #(.WIDTH(16), .DEPTH(5), .AF_LVL(4), .AE_LVL(1), .FWFT(0)) u_reg (
    .i_clk(clk), .i_rst(i_rst), .i_wdata(i_wdata), .i_push(i_push), .i_pop(i_pop),
    .i_flush(i_flush), .o_rdata(r_rdata), .o_full(r_full), .o_empty(r_empty),
    .o_almost_full(r_af), .o_almost_empty(r_ae), .o_count(r_count),
    .o_overflow(r_ovf), .o_underflow(r_udf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FWFT monitor: the head word must be on o_rdata in the cycle its pop is accepted.
  always @(negedge clk) begin
    if (i_pop && !i_rst && !i_flush && !f_empty) begin
      compared++;
      if (q_fwft.size() == 0) begin
        mismatched++;
        $display("FAIL fwft_unexpected_pop: got %0h with empty scoreboard", f_rdata);
      end else begin
        logic [15:0] e;
        e = q_fwft.pop_front();
        if (f_rdata !== e) begin
          mismatched++;
          $display("FAIL fwft_rdata: got %0h expected %0h at %0t", f_rdata, e, $time);
        end
      end
    end
  end

  // Registered-read monitor: the popped word appears one edge after the pop.
  always @(posedge clk) begin
    reg_pend <= i_pop && !r_empty && !i_rst && !i_flush;
  end

  always @(negedge clk) begin
    if (reg_pend) begin
      compared++;
      if (q_reg.size() == 0) begin
        mismatched++;
        $display("FAIL reg_unexpected_pop: got %0h with empty scoreboard", r_rdata);
      end else begin
        logic [15:0] e;
        e = q_reg.pop_front();
        if (r_rdata !== e) begin
          mismatched++;
          $display("FAIL reg_rdata: got %0h expected %0h at %0t", r_rdata, e, $time);
        end
      end
    end
  end

  // One clock of stimulus; inputs change just after the rising edge.
  task automatic step(input logic p, input logic q, input logic [15:0] d, input int exp_cnt);
    i_push = p;
    i_pop = q;
    i_wdata = d;
    if (p && m_cnt < 5) begin
      q_fwft.push_back(d);
      q_reg.push_back(d);
    end
    @(posedge clk);
    #1;
    m_cnt = exp_cnt;
    chk("count_fwft", 32'(f_count), 32'(exp_cnt));
    chk("count_reg", 32'(r_count), 32'(exp_cnt));
    chk("full", 32'(f_full), 32'(exp_cnt == 5));
    chk("empty", 32'(f_empty), 32'(exp_cnt == 0));
  endtask

  task automatic clr_step(input logic use_rst);
    i_push = 1'b1;
    i_pop = 1'b1;
    i_wdata = 16'hDEAD;
    if (use_rst) i_rst = 1'b1;
    else i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    i_flush = 1'b0;
    i_push = 1'b0;
    i_pop = 1'b0;
    q_fwft.delete();
    q_reg.delete();
    m_cnt = 0;
    chk("clr_count", 32'(f_count), 32'd0);
    chk("clr_empty", 32'(f_empty), 32'd1);
    chk("clr_ae", 32'(f_ae), 32'd1);
    chk("clr_af", 32'(f_af), 32'd0);
    chk("clr_ovf", 32'(f_ovf), 32'd0);
    chk("clr_udf", 32'(f_udf), 32'd0);
    chk("clr_reg_rdata", 32'(r_rdata), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    chk("rst_count", 32'(f_count), 32'd0);
    chk("rst_empty", 32'(f_empty), 32'd1);
    chk("rst_full", 32'(f_full), 32'd0);
    chk("rst_ae", 32'(f_ae), 32'd1);
    chk("rst_af", 32'(f_af), 32'd0);
    chk("rst_ovf", 32'(f_ovf), 32'd0);
    chk("rst_udf", 32'(f_udf), 32'd0);
    chk("rst_reg_rdata", 32'(r_rdata), 32'd0);

    // Fill to full.
    step(1, 0, 16'h0011, 1);
    chk("fwft_head_no_pop", 32'(f_rdata), 32'h11);
    chk("ae_at_1", 32'(f_ae), 32'd1);
    step(1, 0, 16'h0022, 2);
    chk("ae_at_2", 32'(f_ae), 32'd0);
    step(1, 0, 16'h0033, 3);
    chk("af_at_3", 32'(f_af), 32'd0);
    step(1, 0, 16'h0044, 4);
    chk("af_at_4", 32'(f_af), 32'd1);
    step(1, 0, 16'h0055, 5);
    chk("af_at_5", 32'(f_af), 32'd1);
    chk("reg_full", 32'(r_full), 32'd1);

    // Overflow: push while full.
    step(1, 0, 16'h0066, 5);
    chk("ovf_pulse", 32'(f_ovf), 32'd1);
    step(0, 0, 16'h0000, 5);
    chk("ovf_clear", 32'(f_ovf), 32'd0);

    // Push+pop at full: pop wins, push rejected with overflow.
    step(1, 1, 16'h0077, 4);
    chk("ovf_pushpop_full", 32'(f_ovf), 32'd1);
    step(0, 1, 16'h0000, 3);
    chk("ovf_clear2", 32'(f_ovf), 32'd0);
    step(0, 1, 16'h0000, 2);
    step(0, 1, 16'h0000, 1);
    step(0, 1, 16'h0000, 0);
    chk("ae_empty", 32'(f_ae), 32'd1);

    // Underflow: pop while empty.
    step(0, 1, 16'h0000, 0);
    chk("udf_pulse", 32'(f_udf), 32'd1);
    step(0, 0, 16'h0000, 0);
    chk("udf_clear", 32'(f_udf), 32'd0);

    // Push+pop at empty: push wins, underflow.
    step(1, 1, 16'h0012, 1);
    chk("udf_pushpop_empty", 32'(f_udf), 32'd1);
    step(1, 0, 16'h0013, 2);
    step(1, 0, 16'h0014, 3);
    // Push+pop at 3: count unchanged, no errors.
    step(1, 1, 16'h0015, 3);
    chk("pp3_ovf", 32'(f_ovf), 32'd0);
    chk("pp3_udf", 32'(f_udf), 32'd0);
    step(0, 1, 16'h0000, 2);

    // Wrap: 23 pushes at count 2 with a pop every cycle.
    for (int i = 0; i < 23; i++) begin
      step(1, 1, 16'h0080 + 16'(i), 2);
      chk("wrap_ovf", 32'(f_ovf), 32'd0);
      chk("wrap_udf", 32'(f_udf), 32'd0);
    end
    step(0, 1, 16'h0000, 1);
    step(0, 1, 16'h0000, 0);

    // Registered read: popped word held while idle.
    step(1, 0, 16'h00A5, 1);
    step(1, 0, 16'h005A, 2);
    step(0, 1, 16'h0000, 1);
    step(0, 0, 16'h0000, 1);
    step(0, 0, 16'h0000, 1);
    chk("reg_hold_a5", 32'(r_rdata), 32'hA5);
    step(0, 1, 16'h0000, 0);
    step(0, 0, 16'h0000, 0);
    chk("reg_after_5a", 32'(r_rdata), 32'h5A);

    // Flush mid-stream at count 3 with push asserted.
    step(1, 0, 16'h0031, 1);
    step(1, 0, 16'h0032, 2);
    step(1, 0, 16'h0033, 3);
    clr_step(1'b0);
    step(1, 0, 16'h0044, 1);
    step(0, 1, 16'h0000, 0);
    step(0, 0, 16'h0000, 0);

    // Reset mid-stream at count 3 with push asserted.
    step(1, 0, 16'h0061, 1);
    step(1, 0, 16'h0062, 2);
    step(1, 0, 16'h0063, 3);
    clr_step(1'b1);
    step(1, 0, 16'h0071, 1);
    step(0, 1, 16'h0000, 0);
    step(0, 0, 16'h0000, 0);

    chk("fwft_scoreboard_drained", 32'(q_fwft.size()), 32'd0);
    chk("reg_scoreboard_drained", 32'(q_reg.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
